// File: rtl/counter_seq_ctrl_pkg.sv
// Shared constants and FSM encoding for the strided counter sequencer and its datapath.
package counter_seq_ctrl_pkg;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned STEP_CNT_W = 8;

  // Counter increment per enabled cycle and counter reset value.
  localparam logic [CNT_W-1:0] CNT_STRIDE  = 16'h0200;
  localparam logic [CNT_W-1:0] CNT_RST_VAL = 16'h0300;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/counter_seq_ctrl_ovf_predict.sv
// Flags a count that would wrap if one more stride were added.
module ovf_predict
  import counter_seq_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH  = CNT_W,
  parameter logic [WIDTH-1:0] STRIDE = CNT_STRIDE
) (
  input  logic [WIDTH-1:0] count_value,
  output logic             ovf_c
);

  // Largest count that can still take one stride without wrapping.
  localparam logic [WIDTH-1:0] LIMIT = {WIDTH{1'b1}} - STRIDE;

  // Pure compare; the sequencer registers the consequence.
  always_comb begin
    ovf_c = (count_value > LIMIT);
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Step sequencer driving the strided counter's ENABLE, with stall, abort and overflow cut-off.
module counter_seq_ctrl
  import counter_seq_ctrl_pkg::*;
#(
  parameter int unsigned      WIDTH  = CNT_W,
  parameter logic [WIDTH-1:0] STRIDE = CNT_STRIDE,
  parameter int unsigned      STEP_W = STEP_CNT_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [STEP_W-1:0] STEPS,
  input  logic              HOLD,
  input  logic              ABORT,
  input  logic [WIDTH-1:0]  count_value,
  output logic              ENABLE,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [STEP_W-1:0] remaining
);

  state_t            state_q;
  state_t            state_d;
  logic              enable_d;
  logic              busy_d;
  logic              done_d;
  logic              err_d;
  logic [STEP_W-1:0] remaining_d;
  logic              ovf_c;

  ovf_predict #(
    .WIDTH  (WIDTH),
    .STRIDE (STRIDE)
  ) u_ovf_predict (
    .count_value (count_value),
    .ovf_c       (ovf_c)
  );

  // State register and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      ENABLE    <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      remaining <= '0;
    end else begin
      state_q   <= state_d;
      ENABLE    <= enable_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      ERR       <= err_d;
      remaining <= remaining_d;
    end
  end

  // Next state and next output values; RUN priority is abort, overflow, hold, step.
  always_comb begin
    state_d     = state_q;
    enable_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = ERR;
    remaining_d = remaining;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          err_d       = 1'b0;
          remaining_d = STEPS;
          state_d     = (STEPS != '0) ? ST_RUN : ST_FINISH;
        end
      end
      ST_RUN: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (ovf_c) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else if (!HOLD) begin
          if (remaining != '0) begin
            enable_d    = 1'b1;
            remaining_d = remaining - STEP_W'(1);
            if (remaining == STEP_W'(1)) begin
              state_d = ST_FINISH;
            end
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // BUSY covers the whole sequence including the DONE cycle; an abort drops it at once.
    busy_d = (state_d != ST_IDLE) || done_d;
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a small strided counter model on count_value.
module tb_counter_seq_ctrl;
  import counter_seq_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [7:0]  STEPS;
  logic        HOLD;
  logic        ABORT;
  logic [15:0] count_value;
  logic        ENABLE;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [7:0]  remaining;

  int total = 0;
  int bad   = 0;

  // Counter model: registered count, count_value is its next value.
  logic [15:0] cnt;
  logic        ld;
  logic [15:0] ld_val;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RESET)       cnt <= CNT_RST_VAL;
    else if (ld)     cnt <= ld_val;
    else if (ENABLE) cnt <= cnt + CNT_STRIDE;
  end

  assign count_value = cnt + (ENABLE ? CNT_STRIDE : 16'h0000);

  counter_seq_ctrl dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .START       (START),
    .STEPS       (STEPS),
    .HOLD        (HOLD),
    .ABORT       (ABORT),
    .count_value (count_value),
    .ENABLE      (ENABLE),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .ERR         (ERR),
    .remaining   (remaining)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic en, input logic busy,
                         input logic done, input logic err, input logic [7:0] rem);
    chk({tag, ".en"},   32'(ENABLE),    32'(en));
    chk({tag, ".busy"}, 32'(BUSY),      32'(busy));
    chk({tag, ".done"}, 32'(DONE),      32'(done));
    chk({tag, ".err"},  32'(ERR),       32'(err));
    chk({tag, ".rem"},  32'(remaining), 32'(rem));
  endtask

  initial begin
    logic [5:0] hold_en;
    logic [7:0] hold_rem [6];

    RESET = 1'b1; START = 1'b0; STEPS = 8'd0; HOLD = 1'b0; ABORT = 1'b0;
    ld = 1'b0; ld_val = 16'h0000;

    // 1: reset held two cycles, then released
    tick(); tick();
    chk_out("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    RESET = 1'b0;
    tick();
    chk_out("rst_rel", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("rst_cnt", 32'(cnt), 32'h0300);

    // 2: three steps from 0x0300, no stall
    START = 1'b1; STEPS = 8'd3;
    tick();
    START = 1'b0;
    chk_out("s3_t", 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
    tick(); chk_out("s3_t1", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
    tick(); chk_out("s3_t2", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    tick(); chk_out("s3_t3", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    tick(); chk_out("s3_done", 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    chk("s3_cnt", 32'(cnt), 32'h0900);
    tick(); chk_out("s3_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // 3: four steps, two-cycle stall after the second ENABLE
    hold_en = 6'b110011;  // bit 5 is the first cycle
    hold_rem[0] = 8'd3; hold_rem[1] = 8'd2; hold_rem[2] = 8'd2;
    hold_rem[3] = 8'd2; hold_rem[4] = 8'd1; hold_rem[5] = 8'd0;
    START = 1'b1; STEPS = 8'd4;
    tick();
    START = 1'b0;
    chk("h4_rem0", 32'(remaining), 32'd4);
    for (int i = 0; i < 6; i++) begin
      HOLD = (i == 2) || (i == 3);
      tick();
      chk($sformatf("h4_en%0d", i),  32'(ENABLE),    32'(hold_en[5-i]));
      chk($sformatf("h4_rem%0d", i+1), 32'(remaining), 32'(hold_rem[i]));
    end
    HOLD = 1'b0;
    tick(); chk_out("h4_done", 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    chk("h4_cnt", 32'(cnt), 32'h1100);
    tick(); chk_out("h4_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // 4: overflow cut-off from 0xFC00
    ld = 1'b1; ld_val = 16'hFC00;
    tick();
    ld = 1'b0;
    START = 1'b1; STEPS = 8'd5;
    tick();
    START = 1'b0;
    chk_out("ov_t", 1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
    tick(); chk_out("ov_t1", 1'b1, 1'b1, 1'b0, 1'b0, 8'd4);
    tick(); chk_out("ov_t2", 1'b0, 1'b1, 1'b0, 1'b1, 8'd4);
    chk("ov_cnt", 32'(cnt), 32'hFE00);
    tick(); chk_out("ov_done", 1'b0, 1'b1, 1'b1, 1'b1, 8'd4);
    tick(); chk_out("ov_idle", 1'b0, 1'b0, 1'b0, 1'b1, 8'd4);
    chk("ov_cnt_end", 32'(cnt), 32'hFE00);

    // 5: ten steps, abort (with hold) after the third ENABLE; START clears ERR
    ld = 1'b1; ld_val = 16'h0300;
    tick();
    ld = 1'b0;
    START = 1'b1; STEPS = 8'd10;
    tick();
    START = 1'b0;
    chk_out("ab_t", 1'b0, 1'b1, 1'b0, 1'b0, 8'd10);
    tick(); chk_out("ab_t1", 1'b1, 1'b1, 1'b0, 1'b0, 8'd9);
    tick(); chk_out("ab_t2", 1'b1, 1'b1, 1'b0, 1'b0, 8'd8);
    tick(); chk_out("ab_t3", 1'b1, 1'b1, 1'b0, 1'b0, 8'd7);
    ABORT = 1'b1; HOLD = 1'b1;
    tick();
    ABORT = 1'b0; HOLD = 1'b0;
    chk_out("ab_t4", 1'b0, 1'b0, 1'b0, 1'b0, 8'd7);
    tick(); chk_out("ab_t5", 1'b0, 1'b0, 1'b0, 1'b0, 8'd7);
    tick(); chk_out("ab_t6", 1'b0, 1'b0, 1'b0, 1'b0, 8'd7);
    chk("ab_cnt", 32'(cnt), 32'h0900);

    // 6a: zero-step START
    START = 1'b1; STEPS = 8'd0;
    tick();
    START = 1'b0;
    chk_out("z_t", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    tick(); chk_out("z_t1", 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    tick(); chk_out("z_t2", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // 6b: START with ABORT in IDLE starts; START mid-RUN ignored
    START = 1'b1; STEPS = 8'd2; ABORT = 1'b1;
    tick();
    START = 1'b0; ABORT = 1'b0;
    chk_out("ig_t", 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    tick(); chk_out("ig_t1", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    START = 1'b1; STEPS = 8'd9;
    tick();
    START = 1'b0;
    chk_out("ig_t2", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    tick(); chk_out("ig_done", 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    tick(); chk_out("ig_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // 6c: RESET mid-RUN wins and gives no DONE
    START = 1'b1; STEPS = 8'd5;
    tick();
    START = 1'b0;
    tick(); chk_out("mr_t1", 1'b1, 1'b1, 1'b0, 1'b0, 8'd4);
    RESET = 1'b1; START = 1'b1; HOLD = 1'b1;
    tick();
    RESET = 1'b0; START = 1'b0; HOLD = 1'b0;
    chk_out("mr_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(); chk_out("mr_after", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(); chk_out("mr_after2", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
